// File: rtl/result_display_pkg.sv
// Shared types and constants for the ALU result BCD display.
// Seven-segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package result_display_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE
  } disp_state_t;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_MINUS   = 7'h3F;
  localparam logic [3:0] SHIFT_COUNT = 4'd8;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

endpackage

// File: rtl/result_bcd_display_seg7.sv
// Digit to active-low seven-segment decoder with blanking.
// Codes 10-15 show nothing.
module seg7_decoder
  import result_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = 7'h40;
        4'd1:    seg = 7'h79;
        4'd2:    seg = 7'h24;
        4'd3:    seg = 7'h30;
        4'd4:    seg = 7'h19;
        4'd5:    seg = 7'h12;
        4'd6:    seg = 7'h02;
        4'd7:    seg = 7'h78;
        4'd8:    seg = 7'h00;
        4'd9:    seg = 7'h10;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/result_bcd_display.sv
// Captures an 8-bit signed ALU result and shows sign plus three
// BCD digits on active-low seven-segment displays.
module result_bcd_display
  import result_display_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] result,
  output logic       busy,
  output logic       done,
  output logic       neg,
  output logic [3:0] bcd_h,
  output logic [3:0] bcd_t,
  output logic [3:0] bcd_o,
  output logic [6:0] hex3,
  output logic [6:0] hex2,
  output logic [6:0] hex1,
  output logic [6:0] hex0
);

  disp_state_t state_q, state_d;
  logic [7:0]  res_q, res_d;
  logic [7:0]  mag_q, mag_d;
  logic [11:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        neg_q, neg_d;
  logic [3:0]  bcd_h_q, bcd_h_d;
  logic [3:0]  bcd_t_q, bcd_t_d;
  logic [3:0]  bcd_o_q, bcd_o_d;
  logic [6:0]  hex3_q, hex3_d;
  logic [6:0]  hex2_q, hex2_d;
  logic [6:0]  hex1_q, hex1_d;
  logic [6:0]  hex0_q, hex0_d;

  logic [11:0] acc_adj;
  logic [19:0] sh;
  logic [11:0] acc_sh;
  logic        blank_h;
  logic        blank_t;
  logic [6:0]  seg_h, seg_t, seg_o;

  assign acc_adj = {add3(acc_q[11:8]),
                    add3(acc_q[7:4]),
                    add3(acc_q[3:0])};
  assign sh      = {acc_adj, mag_q} << 1;
  assign acc_sh  = sh[19:8];
  assign blank_h = (acc_sh[11:8] == 4'd0);
  assign blank_t = blank_h && (acc_sh[7:4] == 4'd0);

  // Decoders look at the final shifted value so the display
  // registers load on the same edge that enters DONE.
  seg7_decoder u_seg_h (
    .digit (acc_sh[11:8]),
    .blank (blank_h),
    .seg   (seg_h)
  );

  seg7_decoder u_seg_t (
    .digit (acc_sh[7:4]),
    .blank (blank_t),
    .seg   (seg_t)
  );

  seg7_decoder u_seg_o (
    .digit (acc_sh[3:0]),
    .blank (1'b0),
    .seg   (seg_o)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    mag_d   = mag_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    neg_d   = neg_q;
    bcd_h_d = bcd_h_q;
    bcd_t_d = bcd_t_q;
    bcd_o_d = bcd_o_q;
    hex3_d  = hex3_q;
    hex2_d  = hex2_q;
    hex1_d  = hex1_q;
    hex0_d  = hex0_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          res_d   = result;
          state_d = LOAD;
        end
      end
      LOAD: begin
        mag_d   = res_q[7] ? (~res_q + 8'd1) : res_q;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        acc_d = acc_sh;
        mag_d = sh[7:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_d == SHIFT_COUNT) begin
          state_d = DONE;
          done_d  = 1'b1;
          neg_d   = res_q[7];
          bcd_h_d = acc_sh[11:8];
          bcd_t_d = acc_sh[7:4];
          bcd_o_d = acc_sh[3:0];
          hex3_d  = res_q[7] ? SEG_MINUS : SEG_BLANK;
          hex2_d  = seg_h;
          hex1_d  = seg_t;
          hex0_d  = seg_o;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      res_q   <= '0;
      mag_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      neg_q   <= 1'b0;
      bcd_h_q <= '0;
      bcd_t_q <= '0;
      bcd_o_q <= '0;
      hex3_q  <= SEG_BLANK;
      hex2_q  <= SEG_BLANK;
      hex1_q  <= SEG_BLANK;
      hex0_q  <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      mag_q   <= mag_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      neg_q   <= neg_d;
      bcd_h_q <= bcd_h_d;
      bcd_t_q <= bcd_t_d;
      bcd_o_q <= bcd_o_d;
      hex3_q  <= hex3_d;
      hex2_q  <= hex2_d;
      hex1_q  <= hex1_d;
      hex0_q  <= hex0_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign neg   = neg_q;
  assign bcd_h = bcd_h_q;
  assign bcd_t = bcd_t_q;
  assign bcd_o = bcd_o_q;
  assign hex3  = hex3_q;
  assign hex2  = hex2_q;
  assign hex1  = hex1_q;
  assign hex0  = hex0_q;

endmodule

// File: tb/tb_result_bcd_display.sv
// Scoreboard bench for result_bcd_display: stimulus pushes
// expected displays, a negedge monitor pops them on done.
module tb_result_bcd_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] result = 8'h00;
  logic       busy, done, neg;
  logic [3:0] bcd_h, bcd_t, bcd_o;
  logic [6:0] hex3, hex2, hex1, hex0;

  typedef struct {
    int         cyc;
    logic       neg;
    logic [3:0] h, t, o;
    logic [6:0] x3, x2, x1, x0;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  result_bcd_display dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .result (result),
    .busy   (busy),
    .done   (done),
    .neg    (neg),
    .bcd_h  (bcd_h),
    .bcd_t  (bcd_t),
    .bcd_o  (bcd_o),
    .hex3   (hex3),
    .hex2   (hex2),
    .hex1   (hex1),
    .hex0   (hex0)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_latency", cyc, e.cyc);
        chk("neg", neg, e.neg);
        chk("bcd_h", bcd_h, e.h);
        chk("bcd_t", bcd_t, e.t);
        chk("bcd_o", bcd_o, e.o);
        chk("hex3", hex3, e.x3);
        chk("hex2", hex2, e.x2);
        chk("hex1", hex1, e.x1);
        chk("hex0", hex0, e.x0);
        chk("busy_in_done", busy, 1);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  // Issue start at the next posedge (E0), then hold start low.
  task automatic accept(input logic [7:0] v);
    @(negedge clk);
    start  = 1'b1;
    result = v;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic convert(
    input logic [7:0] v, input logic n,
    input logic [3:0] h, input logic [3:0] t, input logic [3:0] o,
    input logic [6:0] x3, input logic [6:0] x2,
    input logic [6:0] x1, input logic [6:0] x0);
    exp_t e;
    accept(v);
    e.cyc = cyc + 9;
    e.neg = n;
    e.h = h; e.t = t; e.o = o;
    e.x3 = x3; e.x2 = x2; e.x1 = x1; e.x0 = x0;
    exp_q.push_back(e);
    result = 8'hAA;
    wait_idle();
    @(negedge clk);
    chk("done_low_idle", done, 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_neg", neg, 0);
    chk("rst_bcd", {bcd_h, bcd_t, bcd_o}, 0);
    chk("rst_hex", {hex3, hex2, hex1, hex0}, 28'hFFFFFFF);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk_reset_vals();

    convert(8'h05, 0, 0, 0, 5, 7'h7F, 7'h7F, 7'h7F, 7'h12);
    convert(8'hF9, 1, 0, 0, 7, 7'h3F, 7'h7F, 7'h7F, 7'h78);
    convert(8'h80, 1, 1, 2, 8, 7'h3F, 7'h79, 7'h24, 7'h00);
    convert(8'h7F, 0, 1, 2, 7, 7'h7F, 7'h79, 7'h24, 7'h78);
    convert(8'h00, 0, 0, 0, 0, 7'h7F, 7'h7F, 7'h7F, 7'h40);
    convert(8'h9C, 1, 1, 0, 0, 7'h3F, 7'h79, 7'h40, 7'h40);

    // Display holds while idle and result changes
    result = 8'h33;
    repeat (3) @(negedge clk);
    chk("hold_hex0", hex0, 7'h40);
    chk("hold_neg", neg, 1);

    // Start re-pulsed during SHIFT with a new result is ignored
    begin
      exp_t e;
      accept(8'h2A);
      e.cyc = cyc + 9;
      e.neg = 0; e.h = 0; e.t = 4; e.o = 2;
      e.x3 = 7'h7F; e.x2 = 7'h7F; e.x1 = 7'h19; e.x0 = 7'h24;
      exp_q.push_back(e);
      repeat (3) @(negedge clk);
      result = 8'h01;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      wait_idle();
      repeat (15) @(negedge clk);
      chk("no_queued_conv", busy, 0);
    end

    // Reset during SHIFT aborts without done
    accept(8'h63);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk_reset_vals();

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
